sram_port_arbiter: RTL and testbench

- N-channel arbiter that grants one requesting unit (alpha blend, fill, and future raster/blit engines) exclusive access to the single frame-buffer SRAM port.
- Successor to the fixed two-way alpha/fill SRAM select. Adds a parametrised channel count, a req/gnt handshake, fixed or round-robin priority, burst locking with a burst cap, registered SRAM-side outputs, and read-data return routing to the owning channel.

---
 rtl/sram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: grants one of NUM_CH client channels exclusive use of the
// single frame-buffer SRAM port, registers the SRAM-side access one cycle after
// the owner presents it, and routes read returns back to the issuing channel.
//
// Handshake: a channel raises req and holds it while it wants the port. gnt is
// a registered one-hot grant; while gnt[i] is high, every cycle in which
// channel i drives ch_read_enable/ch_write_enable is one access that the
// arbiter accepts at the next edge (there is no back-pressure on an owned
// port). The grant ends at the edge where the owner drops req, flags last
// with an access, or hits the burst cap with an access; that access is still
// issued. Read data for an issued read comes back on rdata with a one-cycle
// rdata_valid[i] pulse RD_LAT cycles after sram_read_enable was high.
module sram_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 1536,
  parameter int RR_MODE   = 1,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        last,
  input  logic [NUM_CH-1:0]        ch_read_enable,
  input  logic [NUM_CH-1:0]        ch_write_enable,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     sram_read_enable,
  output logic                     sram_write_enable,
  output logic [ADDR_W-1:0]        sram_address,
  output logic [DATA_W-1:0]        sram_write_data,
  input  logic [DATA_W-1:0]        sram_read_data,
  output logic [NUM_CH-1:0]        rdata_valid,
  output logic [DATA_W-1:0]        rdata,
  output logic [0:0]               state_dbg
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam int CAP   = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  int               cand;

  logic              own_req;
  logic              own_last;
  logic              own_rd;
  logic              own_wr;
  logic              own_acc;
  logic              cap_hit;
  logic              release_now;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;

  logic [RD_LAT-1:0] pipe_vld;
  logic [IDX_W-1:0]  pipe_idx [RD_LAT];

  // Arbitration winner: lowest requester, or first requester after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = (int'(ptr_q) + k) % NUM_CH;
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!win_found && req[k]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(k);
        end
      end
    end
  end

  // Select the owning channel's signals and decide whether this edge releases.
  always_comb begin
    own_req     = req[owner_q];
    own_last    = last[owner_q];
    own_rd      = ch_read_enable[owner_q];
    own_wr      = ch_write_enable[owner_q];
    own_addr    = ch_address[owner_q*ADDR_W +: ADDR_W];
    own_data    = ch_write_data[owner_q*DATA_W +: DATA_W];
    own_acc     = own_rd | own_wr;
    cap_hit     = (MAX_BURST != 0) && (cnt_q == CNT_W'(CAP)) && own_acc;
    release_now = ~own_req | (own_last & own_acc) | cap_hit;
  end

  // Grant FSM and registered SRAM-side access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      gnt               <= '0;
      owner_q           <= '0;
      ptr_q             <= IDX_W'(NUM_CH - 1);
      cnt_q             <= '0;
      sram_read_enable  <= 1'b0;
      sram_write_enable <= 1'b0;
      sram_address      <= '0;
      sram_write_data   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sram_read_enable  <= 1'b0;
          sram_write_enable <= 1'b0;
          if (win_found) begin
            state_q <= ST_OWN;
            gnt     <= NUM_CH'(1) << win_idx;
            owner_q <= win_idx;
            cnt_q   <= '0;
            ptr_q   <= win_idx;
          end
        end
        ST_OWN: begin
          // Write wins over a simultaneous read.
          sram_read_enable  <= own_rd & ~own_wr;
          sram_write_enable <= own_wr;
          sram_address      <= own_addr;
          sram_write_data   <= own_data;
          if (own_acc) cnt_q <= cnt_q + CNT_W'(1);
          if (release_now) begin
            state_q <= ST_IDLE;
            gnt     <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt     <= '0;
        end
      endcase
    end
  end

  // Read-tag pipeline: stage 0 captures the strobe already on the SRAM port.
  // owner_q still names the issuing channel here, because a new owner can only
  // be loaded one edge after the grant is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_idx[k] <= '0;
    end else begin
      pipe_vld[0] <= sram_read_enable;
      pipe_idx[0] <= owner_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  // Return routing and debug visibility.
  always_comb begin
    rdata       = sram_read_data;
    rdata_valid = pipe_vld[RD_LAT-1] ? (NUM_CH'(1) << pipe_idx[RD_LAT-1]) : '0;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: drives a round-robin and a fixed-priority instance
// with the same inputs; checks a vector table, hand sequences for the
// multi-cycle corners, and random traffic against a behavioural model.
module tb_sram_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 64;
  localparam int MB  = 4;
  localparam int RL  = 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH-1:0]    req, last, rd, wr;
  logic [NCH*AW-1:0] ch_address;
  logic [NCH*DW-1:0] ch_write_data;
  logic [DW-1:0]     sram_read_data;

  logic [NCH-1:0] gnt_rr, gnt_fx, rv_rr, rv_fx;
  logic           re_rr, re_fx, we_rr, we_fx;
  logic [AW-1:0]  addr_rr, addr_fx;
  logic [DW-1:0]  wdata_rr, wdata_fx, rdata_rr, rdata_fx;
  logic [0:0]     st_rr, st_fx;

  sram_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1),
                      .MAX_BURST(MB), .RD_LAT(RL)) u_rr (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .ch_read_enable(rd), .ch_write_enable(wr),
    .ch_address(ch_address), .ch_write_data(ch_write_data),
    .gnt(gnt_rr), .sram_read_enable(re_rr), .sram_write_enable(we_rr),
    .sram_address(addr_rr), .sram_write_data(wdata_rr),
    .sram_read_data(sram_read_data), .rdata_valid(rv_rr), .rdata(rdata_rr),
    .state_dbg(st_rr)
  );

  sram_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0),
                      .MAX_BURST(MB), .RD_LAT(RL)) u_fx (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .ch_read_enable(rd), .ch_write_enable(wr),
    .ch_address(ch_address), .ch_write_data(ch_write_data),
    .gnt(gnt_fx), .sram_read_enable(re_fx), .sram_write_enable(we_fx),
    .sram_address(addr_fx), .sram_write_data(wdata_fx),
    .sram_read_data(sram_read_data), .rdata_valid(rv_fx), .rdata(rdata_fx),
    .state_dbg(st_fx)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = fixed priority, 1 = round-robin.
  typedef struct { int inst; int due; int ch; } ret_t;
  ret_t exp_q[$];
  int   cyc = 0;

  int            m_own [2];
  int            m_cnt [2];
  int            m_ptr [2];
  logic [NCH-1:0] m_gnt [2];
  logic          m_re  [2];
  logic          m_we  [2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];

  function automatic int pick(input int k);
    int j;
    if (k == 0) begin
      for (int c = 0; c < NCH; c++) if (req[c]) return c;
    end else begin
      for (int s = 1; s <= NCH; s++) begin
        j = (m_ptr[k] + s) % NCH;
        if (req[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step();
    int  nc;
    int  w;
    int  i;
    bit  acc;
    nc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = NCH - 1; m_gnt[k] = '0;
        m_re[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
      end else if (m_own[k] < 0) begin
        m_re[k] = 1'b0;
        m_we[k] = 1'b0;
        if (req != '0) begin
          w = pick(k);
          m_own[k] = w; m_cnt[k] = 0; m_ptr[k] = w;
          m_gnt[k] = NCH'(1) << w;
        end
      end else begin
        i   = m_own[k];
        acc = rd[i] | wr[i];
        m_we[k]   = wr[i];
        m_re[k]   = rd[i] & ~wr[i];
        m_addr[k] = ch_address[i*AW +: AW];
        m_data[k] = ch_write_data[i*DW +: DW];
        if (m_re[k]) exp_q.push_back('{k, nc + RL, i});
        if (!req[i] || (last[i] && acc) || (MB != 0 && m_cnt[k] == MB - 1 && acc)) begin
          m_own[k] = -1;
          m_gnt[k] = '0;
        end
        if (acc) m_cnt[k]++;
      end
    end
    if (rst) exp_q.delete();
    cyc = nc;
  endtask

  task automatic check_model();
    logic [NCH-1:0] e;
    ret_t keep[$];
    for (int k = 0; k < 2; k++) begin
      e = '0;
      foreach (exp_q[n]) if (exp_q[n].inst == k && exp_q[n].due == cyc) e |= NCH'(1) << exp_q[n].ch;
      check($sformatf("m_gnt%0d", k),   k ? gnt_rr   : gnt_fx,   m_gnt[k]);
      check($sformatf("m_re%0d", k),    k ? re_rr    : re_fx,    m_re[k]);
      check($sformatf("m_we%0d", k),    k ? we_rr    : we_fx,    m_we[k]);
      check($sformatf("m_addr%0d", k),  k ? addr_rr  : addr_fx,  m_addr[k]);
      check($sformatf("m_wdata%0d", k), k ? wdata_rr : wdata_fx, m_data[k]);
      check($sformatf("m_rv%0d", k),    k ? rv_rr    : rv_fx,    e);
    end
    check("rdata_pass", rdata_rr, sram_read_data);
    foreach (exp_q[n]) if (exp_q[n].due > cyc) keep.push_back(exp_q[n]);
    exp_q = keep;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    rst = 1'b0; req = '0; last = '0; rd = '0; wr = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_address[c*AW +: AW]    = a;
    ch_write_data[c*DW +: DW] = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           rst;
    logic [NCH-1:0] req, last, rd, wr;
    logic [NCH-1:0] gnt_rr, gnt_fx;
    logic           re;
    logic [NCH-1:0] rv_rr, rv_fx;
  } vec_t;

  vec_t vecs[15];

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_55;
  int            re_cnt;

  initial begin
    pat_a5 = {8{8'hA5}};
    pat_55 = {8{8'h55}};
    clear_inputs();
    rst = 1'b1;
    ch_address = '0; ch_write_data = '0; sram_read_data = '0;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = NCH - 1; m_gnt[k] = '0;
      m_re[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
    end
    for (int c = 0; c < NCH; c++) set_ch(c, AW'(24'h100 + c), DW'(c + 1));

    // rst, req, last, rd, wr, gnt_rr, gnt_fx, re, rv_rr, rv_fx
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h2, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1};
    vecs[6]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h4, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[7]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 4'h2, 4'h1};
    vecs[8]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h8, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h1};
    vecs[10] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 4'h8, 4'h1};
    vecs[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    vecs[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1};
    vecs[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};

    // Reset, round-robin rotation and fixed-priority starvation.
    for (int v = 0; v < 15; v++) begin
      rst = vecs[v].rst; req = vecs[v].req; last = vecs[v].last;
      rd = vecs[v].rd; wr = vecs[v].wr;
      tick();
      check($sformatf("vec%0d_gnt_rr", v), gnt_rr, vecs[v].gnt_rr);
      check($sformatf("vec%0d_gnt_fx", v), gnt_fx, vecs[v].gnt_fx);
      check($sformatf("vec%0d_re_rr", v),  re_rr,  vecs[v].re);
      check($sformatf("vec%0d_re_fx", v),  re_fx,  vecs[v].re);
      check($sformatf("vec%0d_rv_rr", v),  rv_rr,  vecs[v].rv_rr);
      check($sformatf("vec%0d_rv_fx", v),  rv_fx,  vecs[v].rv_fx);
    end

    // Write path on channel 1.
    idle(3);
    req = 4'b0010;
    tick();
    check("wr_gnt", gnt_rr, 4'b0010);
    wr = 4'b0010; last = 4'b0010;
    set_ch(1, 24'h001234, pat_a5);
    tick();
    check("wr_we", we_rr, 1'b1);
    check("wr_re", re_rr, 1'b0);
    check("wr_addr", addr_rr, 24'h001234);
    check("wr_data", wdata_rr, pat_a5);
    check("wr_gnt_clr", gnt_rr, 4'b0000);
    clear_inputs();
    tick();
    check("wr_we_drop", we_rr, 1'b0);

    // Read return routed to channel 3 while channel 0 owns the port.
    idle(3);
    req = 4'b1000;
    tick();
    check("rd_gnt3", gnt_rr, 4'b1000);
    rd = 4'b1000; last = 4'b1000; req = 4'b1001;
    set_ch(3, 24'h000010, DW'(0));
    tick();
    check("rd_re", re_rr, 1'b1);
    check("rd_addr", addr_rr, 24'h000010);
    rd = '0; last = '0; req = 4'b0001;
    tick();
    check("rd_gnt0", gnt_rr, 4'b0001);
    check("rd_rv_early", rv_rr, 4'b0000);
    sram_read_data = pat_55;
    tick();
    check("rd_rv3", rv_rr, 4'b1000);
    check("rd_rdata", rdata_rr, pat_55);
    tick();
    check("rd_rv_once", rv_rr, 4'b0000);
    idle(3);

    // Burst cap: channel 2 streams reads without last.
    req = 4'b0100; rd = 4'b0100;
    tick();
    check("cap_gnt", gnt_rr, 4'b0100);
    re_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (re_rr) re_cnt++;
    end
    check("cap_reads", 64'(re_cnt), 64'd4);
    check("cap_gnt_drop", gnt_rr, 4'b0000);
    tick();
    check("cap_regrant", gnt_rr, 4'b0100);
    check("cap_dead_re", re_rr, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    idle(4);

    // Conflicting strobes, then reset with two reads in flight.
    req = 4'b0001;
    tick();
    rd = 4'b0001; wr = 4'b0001;
    tick();
    check("conf_we", we_rr, 1'b1);
    check("conf_re", re_rr, 1'b0);
    wr = '0;
    tick();
    tick();
    check("inflight_re", re_rr, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_gnt", gnt_rr, 4'b0000);
    check("rst_re", re_rr, 1'b0);
    check("rst_we", we_rr, 1'b0);
    check("rst_addr", addr_rr, 24'h0);
    check("rst_rv", rv_rr, 4'b0000);
    tick();
    check("rst_rv2", rv_rr, 4'b0000);
    rst = 1'b0; req = '0; rd = '0;
    tick();
    check("rst_rv3", rv_rr, 4'b0000);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst  = ($urandom_range(0, 249) == 0);
      req  = NCH'($urandom | $urandom);
      last = NCH'($urandom & $urandom);
      rd   = NCH'($urandom);
      wr   = NCH'($urandom & $urandom);
      for (int c = 0; c < NCH; c++) set_ch(c, AW'($urandom), {$urandom, $urandom});
      sram_read_data = {$urandom, $urandom};
      tick();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
